// File: rtl/cache_dma_bridge.sv
// Purpose: turns one cache line fill/writeback request into a single-line DMA transfer at base_addr+cpu_addr.
// Latency: accept at cycle 0, dma go at 1, data move at 2 (earliest), done sampled at 3, tx_done at 4, ready again at 5.
// Backpressure: one request in flight; ready low while busy, XFER stalls on dma_empty/dma_full, DONE waits for the done level.
// Ports: cache side (enable, base_addr, mem_op, cpu_addr, wr_line -> ready, rd_line, rd_valid, tx_done, illegal_op, counters);
//        DMA side (go/addr/size per channel, dma_rd_en/dma_rd_data/dma_empty/dma_rd_done, dma_wr_en/dma_wr_data/dma_full/dma_wr_done).
module cache_dma_bridge #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WIDTH = 512,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [1:0]            mem_op,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [LINE_WIDTH-1:0] wr_line,
    output logic                  ready,
    output logic [LINE_WIDTH-1:0] rd_line,
    output logic                  rd_valid,
    output logic                  tx_done,
    output logic                  illegal_op,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic                  dma_rd_go,
    output logic                  dma_wr_go,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [ADDR_WIDTH:0]   dma_rd_size,
    output logic [ADDR_WIDTH:0]   dma_wr_size,
    input  logic                  dma_empty,
    input  logic [LINE_WIDTH-1:0] dma_rd_data,
    output logic                  dma_rd_en,
    input  logic                  dma_rd_done,
    input  logic                  dma_full,
    output logic                  dma_wr_en,
    output logic [LINE_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_wr_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_XFER,
        S_DONE,
        S_RESP
    } state_t;

    state_t                state, state_nxt;
    logic                  op_wr;      // 0: fill (read), 1: writeback
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wr_q;
    logic [ADDR_WIDTH-1:0] line_sum;
    logic                  accept;
    logic                  bad_op;

    // Carry out of the add is dropped: the address wraps modulo 2^ADDR_WIDTH.
    assign line_sum    = base_addr + cpu_addr;

    assign dma_rd_addr = addr_q;
    assign dma_wr_addr = addr_q;
    assign dma_rd_size = {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign dma_wr_size = {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign dma_wr_data = wr_q;

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        bad_op    = 1'b0;
        rd_valid  = 1'b0;
        tx_done   = 1'b0;
        dma_rd_go = 1'b0;
        dma_wr_go = 1'b0;
        dma_rd_en = 1'b0;
        dma_wr_en = 1'b0;
        case (state)
            S_IDLE: begin
                ready  = 1'b1;
                accept = enable && (mem_op == 2'b01 || mem_op == 2'b10);
                bad_op = enable && (mem_op == 2'b11);
                if (accept) state_nxt = S_GO;
            end
            S_GO: begin
                dma_rd_go = !op_wr;
                dma_wr_go = op_wr;
                state_nxt = S_XFER;
            end
            S_XFER: begin
                // A single pop/push per transfer; the state leaves XFER on that same cycle.
                if (op_wr) dma_wr_en = !dma_full;
                else       dma_rd_en = !dma_empty;
                if (op_wr ? !dma_full : !dma_empty) state_nxt = S_DONE;
            end
            S_DONE: begin
                // Done is first looked at two cycles after go, so a level left over
                // from the previous transfer has already cleared.
                if (op_wr ? dma_wr_done : dma_rd_done) state_nxt = S_RESP;
            end
            S_RESP: begin
                tx_done   = 1'b1;
                rd_valid  = !op_wr;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // While reset is held nothing may be accepted or strobed.
        if (rst) begin
            ready     = 1'b0;
            accept    = 1'b0;
            bad_op    = 1'b0;
            rd_valid  = 1'b0;
            tx_done   = 1'b0;
            dma_rd_go = 1'b0;
            dma_wr_go = 1'b0;
            dma_rd_en = 1'b0;
            dma_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wr_q       <= '0;
            rd_line    <= '0;
            illegal_op <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_wr  <= mem_op[1];
                addr_q <= {line_sum[ADDR_WIDTH-1:6], 6'b0};
                wr_q   <= wr_line;
            end
            if (bad_op)    illegal_op <= 1'b1;
            if (dma_rd_en) rd_line    <= dma_rd_data;
            if (tx_done) begin
                if (op_wr) wr_count <= wr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                else       rd_count <= rd_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_cache_dma_bridge.sv
// Bench for cache_dma_bridge: directed read/write/illegal/reset sequences, a transaction-level
// model checked against the DUT every cycle, plus literal expectations at key points.
module tb_cache_dma_bridge;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [63:0]  base_addr;
    logic [1:0]   mem_op;
    logic [63:0]  cpu_addr;
    logic [511:0] wr_line;
    logic         ready;
    logic [511:0] rd_line;
    logic         rd_valid;
    logic         tx_done;
    logic         illegal_op;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;
    logic         dma_rd_go;
    logic         dma_wr_go;
    logic [63:0]  dma_rd_addr;
    logic [63:0]  dma_wr_addr;
    logic [64:0]  dma_rd_size;
    logic [64:0]  dma_wr_size;
    logic         dma_empty;
    logic [511:0] dma_rd_data;
    logic         dma_rd_en;
    logic         dma_rd_done;
    logic         dma_full;
    logic         dma_wr_en;
    logic [511:0] dma_wr_data;
    logic         dma_wr_done;

    int n_cmp = 0;
    int n_err = 0;

    cache_dma_bridge dut (
        .clk(clk), .rst(rst), .enable(enable), .base_addr(base_addr), .mem_op(mem_op),
        .cpu_addr(cpu_addr), .wr_line(wr_line), .ready(ready), .rd_line(rd_line),
        .rd_valid(rd_valid), .tx_done(tx_done), .illegal_op(illegal_op),
        .rd_count(rd_count), .wr_count(wr_count), .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
        .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr), .dma_rd_size(dma_rd_size),
        .dma_wr_size(dma_wr_size), .dma_empty(dma_empty), .dma_rd_data(dma_rd_data),
        .dma_rd_en(dma_rd_en), .dma_rd_done(dma_rd_done), .dma_full(dma_full),
        .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data), .dma_wr_done(dma_wr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model + per-cycle compare ----------------
    // One outstanding request: age 1 is the go cycle, afterwards the line moves on the
    // first non-stalled cycle, then completion follows the cycle after done is seen.
    bit           m_busy, m_wr, m_moved, m_finished, m_ill;
    int           m_age;
    logic [63:0]  m_addr;
    logic [511:0] m_wline, m_rdline;
    logic [31:0]  m_rdcnt, m_wrcnt;

    initial begin
        bit e_ready, e_go, e_xfer, e_rd_en, e_wr_en, e_resp;
        logic [6:0] e_str;
        m_busy = 0; m_wr = 0; m_moved = 0; m_finished = 0; m_ill = 0; m_age = 0;
        m_addr = '0; m_wline = '0; m_rdline = '0; m_rdcnt = '0; m_wrcnt = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_ready = !rst && !m_busy;
            e_go    = !rst && m_busy && m_age == 1;
            e_xfer  = !rst && m_busy && m_age == 2 && !m_moved;
            e_rd_en = e_xfer && !m_wr && !dma_empty;
            e_wr_en = e_xfer && m_wr && !dma_full;
            e_resp  = !rst && m_busy && m_finished;
            e_str   = {e_resp && !m_wr, e_resp, e_go && !m_wr, e_go && m_wr, e_rd_en, e_wr_en, m_ill};
            check("cyc_ready", ready, e_ready);
            check("cyc_strobes{rv,td,rgo,wgo,ren,wen,ill}",
                  {rd_valid, tx_done, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en, illegal_op}, e_str);
            check("cyc_rd_addr", dma_rd_addr, m_addr);
            check("cyc_wr_addr", dma_wr_addr, m_addr);
            check("cyc_sizes", {dma_rd_size, dma_wr_size}, {65'd1, 65'd1});
            check("cyc_rd_line", rd_line, m_rdline);
            check("cyc_counts", {rd_count, wr_count}, {m_rdcnt, m_wrcnt});
            if (e_wr_en) check("cyc_wr_data", dma_wr_data, m_wline);
            // advance the model to what the next edge must produce
            if (rst) begin
                m_busy = 0; m_ill = 0; m_addr = '0; m_wline = '0; m_rdline = '0;
                m_rdcnt = '0; m_wrcnt = '0;
            end else if (!m_busy) begin
                if (enable && mem_op == 2'b11) m_ill = 1;
                if (enable && (mem_op == 2'b01 || mem_op == 2'b10)) begin
                    m_busy = 1; m_age = 1; m_moved = 0; m_finished = 0;
                    m_wr = (mem_op == 2'b10);
                    m_addr = (base_addr + cpu_addr) & ~64'h3F;
                    m_wline = wr_line;
                end
            end else if (m_finished) begin
                m_busy = 0;
                if (m_wr) m_wrcnt = m_wrcnt + 1; else m_rdcnt = m_rdcnt + 1;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (!m_moved) begin
                if (!m_wr && !dma_empty) begin
                    m_moved = 1;
                    m_rdline = dma_rd_data;
                end else if (m_wr && !dma_full) begin
                    m_moved = 1;
                end
            end else if (m_wr ? dma_wr_done : dma_rd_done) begin
                m_finished = 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read with the line available on the first XFER cycle; optionally a stale done level
    // is held through accept/go and completion comes two cycles later than minimum.
    task automatic run_read(input logic [63:0] b, input logic [63:0] off, input logic [511:0] d,
                            input bit stale, input logic [63:0] exp_addr, input logic [31:0] exp_cnt);
        base_addr = b; cpu_addr = off; mem_op = 2'b01; enable = 1'b1;
        dma_empty = 1'b1; dma_rd_done = stale;
        step();                              // cycle 1: go
        #1 check("rd_go_pulse", dma_rd_go, 1'b1);
        step();                              // cycle 2: line available
        dma_rd_done = 1'b0; dma_empty = 1'b0; dma_rd_data = d;
        #1 check("rd_en_pulse", dma_rd_en, 1'b1);
        step();                              // cycle 3
        dma_empty = 1'b1;
        if (stale) begin
            step();
            step();
        end
        dma_rd_done = 1'b1;
        step();                              // completion cycle
        mem_op = 2'b00; dma_rd_done = 1'b0;
        #1;
        check("rd_tx_done", tx_done, 1'b1);
        check("rd_valid", rd_valid, 1'b1);
        check("rd_line", rd_line, d);
        check("rd_addr", dma_rd_addr, exp_addr);
        check("rd_size", dma_rd_size, 65'd1);
        step();
        #1;
        check("rd_ready_again", ready, 1'b1);
        check("rd_count", rd_count, exp_cnt);
    endtask

    // Writeback with the channel full for full_cycles cycles starting at the first XFER cycle.
    task automatic run_write(input logic [63:0] b, input logic [63:0] off, input logic [511:0] d,
                             input int full_cycles, input logic [63:0] exp_addr, input logic [31:0] exp_cnt);
        base_addr = b; cpu_addr = off; wr_line = d; mem_op = 2'b10; enable = 1'b1;
        dma_full = 1'b1; dma_wr_done = 1'b0;
        step();                              // go
        #1 check("wr_go_pulse", dma_wr_go, 1'b1);
        step();                              // first XFER cycle, still full
        #1 check("wr_en_held_off", dma_wr_en, 1'b0);
        repeat (full_cycles) step();
        dma_full = 1'b0;
        #1;
        check("wr_en_pulse", dma_wr_en, 1'b1);
        check("wr_data", dma_wr_data, d);
        step();
        dma_wr_done = 1'b1;
        #1 check("wr_en_single", dma_wr_en, 1'b0);
        step();
        mem_op = 2'b00; dma_wr_done = 1'b0;
        #1;
        check("wr_tx_done", tx_done, 1'b1);
        check("wr_no_rd_valid", rd_valid, 1'b0);
        check("wr_addr", dma_wr_addr, exp_addr);
        step();
        #1 check("wr_count", wr_count, exp_cnt);
    endtask

    initial begin
        logic [511:0] pat_a, pat_b, pat_c;
        pat_a = {8{64'h0123_4567_89AB_CDEF}};
        pat_b = {64{8'hA5}};
        pat_c = {16{32'hDEAD_BEEF}};
        rst = 1'b1; enable = 1'b0; base_addr = '0; mem_op = 2'b00; cpu_addr = '0; wr_line = '0;
        dma_empty = 1'b1; dma_rd_data = '0; dma_rd_done = 1'b0; dma_full = 1'b0; dma_wr_done = 1'b0;
        step();
        step();
        #1 check("reset_ready_forced_low", ready, 1'b0);
        rst = 1'b0;
        step();
        #1;
        check("reset_ready", ready, 1'b1);
        check("reset_counts", {rd_count, wr_count}, 64'd0);
        check("reset_rd_line", rd_line, 512'd0);

        // basic fill at minimum latency
        run_read(64'h1000_0000, 64'h40, pat_a, 1'b0, 64'h1000_0040, 32'd1);
        // unaligned writeback with three full cycles
        run_write(64'h1000_0000, 64'h7F, pat_b, 3, 64'h1000_0040, 32'd1);
        // stale done level from a previous transfer must not end this one early
        run_read(64'h1000_0000, 64'h1C0, pat_c, 1'b1, 64'h1000_01C0, 32'd2);
        check("rd_line_held", rd_line, pat_c);

        // reserved op: sticky flag, no transfer
        enable = 1'b1; mem_op = 2'b11;
        step();
        mem_op = 2'b00;
        #1;
        check("illegal_set", illegal_op, 1'b1);
        check("illegal_ready", ready, 1'b1);
        check("illegal_no_go", {dma_rd_go, dma_wr_go}, 2'b00);
        // disabled request is ignored
        enable = 1'b0; mem_op = 2'b01;
        step();
        step();
        #1;
        check("disabled_no_go", dma_rd_go, 1'b0);
        check("disabled_ready", ready, 1'b1);
        check("illegal_sticky", illegal_op, 1'b1);
        mem_op = 2'b00;
        step();

        // reset while stalled in XFER
        base_addr = 64'h2000_0000; cpu_addr = 64'h0; mem_op = 2'b01; enable = 1'b1; dma_empty = 1'b1;
        step();                              // go
        step();                              // XFER, empty
        rst = 1'b1;
        #1 check("rst_mid_ready_low", ready, 1'b0);
        step();
        rst = 1'b0; mem_op = 2'b00;
        #1;
        check("rst_mid_strobes", {rd_valid, tx_done, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en, illegal_op}, 7'd0);
        check("rst_mid_counts", {rd_count, wr_count}, 64'd0);
        check("rst_mid_ready", ready, 1'b1);
        check("rst_mid_addr", dma_rd_addr, 64'd0);
        run_read(64'h2000_0000, 64'h80, pat_a, 1'b0, 64'h2000_0080, 32'd1);

        // address wraps past 2^64
        run_read(64'hFFFF_FFFF_FFFF_FFC0, 64'h80, pat_b, 1'b0, 64'h40, 32'd2);
        check("final_wr_count", wr_count, 32'd0);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
